// File: rtl/axi_pkg.sv
// Shared AXI constants and the read-responder state encoding.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [2:0] SIZE_4B     = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_BURST
    } rd_state_e;

    // A request is unserviceable when it is not a word-aligned 4-byte INCR burst.
    function automatic logic req_error(input logic [1:0] addr_lo,
                                       input logic [2:0] size,
                                       input logic [1:0] burst);
        return (addr_lo != 2'b00) || (size != SIZE_4B) || (burst != BURST_INCR);
    endfunction

endpackage

// File: rtl/rd_mem.sv
// Word array with a backdoor write port and a registered read port.
// The read register doubles as the R-channel data register; rd_zero
// loads zero instead of memory contents for error beats.
module rd_mem #(
    parameter int DEPTH = 4096,
    parameter int WIDTH = 32,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic             rd_zero,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Backdoor write; storage keeps its contents across reset.
    // NOTE: the array has no reset so it maps onto RAM and survives rst.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Output data register: same-cycle write returns the old word.
    // NOTE: non-blocking assignments in clocked blocks give read-before-write ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_zero ? '0 : mem[rd_addr];
        end
    end

endmodule

// File: rtl/axi_rd_responder.sv
// AXI4 read-channel completer: accepts one INCR burst at a time, waits
// RD_LAT cycles, then streams beats from rd_mem honouring rready.
module axi_rd_responder
    import axi_pkg::*;
#(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 4096,
    parameter int RD_LAT     = 2,
    localparam int MEM_AW    = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   arid_s_inf,
    input  logic [ADDR_WIDTH-1:0] araddr_s_inf,
    input  logic [3:0]            arlen_s_inf,
    input  logic [2:0]            arsize_s_inf,
    input  logic [1:0]            arburst_s_inf,
    input  logic                  arvalid_s_inf,
    output logic                  arready_s_inf,
    output logic [ID_WIDTH-1:0]   rid_s_inf,
    output logic [DATA_WIDTH-1:0] rdata_s_inf,
    output logic [1:0]            rresp_s_inf,
    output logic                  rlast_s_inf,
    output logic                  rvalid_s_inf,
    input  logic                  rready_s_inf,
    input  logic                  ld_en,
    input  logic [MEM_AW-1:0]     ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data
);

    localparam int WA = ADDR_WIDTH - 2;
    localparam logic [WA-1:0] WORD_DEPTH = WA'(MEM_DEPTH);

    rd_state_e           state, state_nxt;
    logic [3:0]          wait_cnt, wait_cnt_nxt;
    logic [WA-1:0]       cur_addr, cur_addr_nxt;
    logic [3:0]          beat_idx, beat_idx_nxt;
    logic [3:0]          len, len_nxt;
    logic                req_err, req_err_nxt;
    logic [ID_WIDTH-1:0] rid_nxt;
    logic [1:0]          rresp_nxt;
    logic                rlast_nxt, rvalid_nxt, arready_nxt;

    // Beat-load bundle: when load is high the output registers take the
    // beat described by ld_word / ld_err / ld_idx / ld_len this edge.
    logic                load;
    logic [WA-1:0]       ld_word;
    logic                ld_err;
    logic                ld_range_err;
    logic [3:0]          ld_idx;
    logic [3:0]          ld_len;

    // Next-state, next-output and beat-load decisions.
    // NOTE: every signal gets a default first so no path infers a latch.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        cur_addr_nxt = cur_addr;
        beat_idx_nxt = beat_idx;
        len_nxt      = len;
        req_err_nxt  = req_err;
        rid_nxt      = rid_s_inf;
        rresp_nxt    = rresp_s_inf;
        rlast_nxt    = rlast_s_inf;
        rvalid_nxt   = rvalid_s_inf;
        arready_nxt  = arready_s_inf;
        load         = 1'b0;
        ld_word      = cur_addr;
        ld_err       = req_err;
        ld_idx       = beat_idx;
        ld_len       = len;

        case (state)
            ST_IDLE: begin
                arready_nxt = 1'b1;
                if (arvalid_s_inf && arready_s_inf) begin
                    rid_nxt      = arid_s_inf;
                    len_nxt      = arlen_s_inf;
                    req_err_nxt  = req_error(araddr_s_inf[1:0], arsize_s_inf, arburst_s_inf);
                    cur_addr_nxt = araddr_s_inf[ADDR_WIDTH-1:2];
                    beat_idx_nxt = '0;
                    arready_nxt  = 1'b0;
                    if (RD_LAT == 0) begin
                        load    = 1'b1;
                        ld_word = araddr_s_inf[ADDR_WIDTH-1:2];
                        ld_err  = req_error(araddr_s_inf[1:0], arsize_s_inf, arburst_s_inf);
                        ld_idx  = '0;
                        ld_len  = arlen_s_inf;
                    end else begin
                        wait_cnt_nxt = 4'(RD_LAT - 1);
                        state_nxt    = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt == '0) begin
                    load = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt - 4'd1;
                end
            end
            ST_BURST: begin
                if (rvalid_s_inf && rready_s_inf) begin
                    if (rlast_s_inf) begin
                        state_nxt   = ST_IDLE;
                        rvalid_nxt  = 1'b0;
                        rlast_nxt   = 1'b0;
                        arready_nxt = 1'b1;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Beats past the end of memory fail individually; no 4 KB wrap.
        ld_range_err = (ld_word >= WORD_DEPTH);

        if (load) begin
            state_nxt    = ST_BURST;
            rvalid_nxt   = 1'b1;
            rlast_nxt    = (ld_idx == ld_len);
            rresp_nxt    = (ld_err || ld_range_err) ? RESP_SLVERR : RESP_OKAY;
            cur_addr_nxt = ld_word + WA'(1);
            beat_idx_nxt = ld_idx + 4'd1;
        end
    end

    // State and registered-output update; reset discards any burst in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            wait_cnt      <= '0;
            cur_addr      <= '0;
            beat_idx      <= '0;
            len           <= '0;
            req_err       <= 1'b0;
            rid_s_inf     <= '0;
            rresp_s_inf   <= RESP_OKAY;
            rlast_s_inf   <= 1'b0;
            rvalid_s_inf  <= 1'b0;
            arready_s_inf <= 1'b0;
        end else begin
            state         <= state_nxt;
            wait_cnt      <= wait_cnt_nxt;
            cur_addr      <= cur_addr_nxt;
            beat_idx      <= beat_idx_nxt;
            len           <= len_nxt;
            req_err       <= req_err_nxt;
            rid_s_inf     <= rid_nxt;
            rresp_s_inf   <= rresp_nxt;
            rlast_s_inf   <= rlast_nxt;
            rvalid_s_inf  <= rvalid_nxt;
            arready_s_inf <= arready_nxt;
        end
    end

    rd_mem #(
        .DEPTH (MEM_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_rd_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (ld_en),
        .wr_addr (ld_addr),
        .wr_data (ld_data),
        .rd_en   (load),
        .rd_zero (ld_err || ld_range_err),
        .rd_addr (ld_word[MEM_AW-1:0]),
        .rd_data (rdata_s_inf)
    );

endmodule

// File: tb/tb_axi_rd_responder.sv
// Directed bench for axi_rd_responder (RD_LAT=2, MEM_DEPTH=4096).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_axi_rd_responder;

    logic        clk;
    logic        rst;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        ld_en;
    logic [11:0] ld_addr;
    logic [31:0] ld_data;

    axi_rd_responder #(
        .ID_WIDTH   (4),
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .MEM_DEPTH  (4096),
        .RD_LAT     (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .arid_s_inf    (arid),
        .araddr_s_inf  (araddr),
        .arlen_s_inf   (arlen),
        .arsize_s_inf  (arsize),
        .arburst_s_inf (arburst),
        .arvalid_s_inf (arvalid),
        .arready_s_inf (arready),
        .rid_s_inf     (rid),
        .rdata_s_inf   (rdata),
        .rresp_s_inf   (rresp),
        .rlast_s_inf   (rlast),
        .rvalid_s_inf  (rvalid),
        .rready_s_inf  (rready),
        .ld_en         (ld_en),
        .ld_addr       (ld_addr),
        .ld_data       (ld_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic [31:0] got_data [16];
    logic [3:0]  got_id   [16];
    logic [1:0]  got_resp [16];
    logic        got_last [16];
    int          got_cyc  [16];
    int          nb;
    int          first_cyc;
    int          hs_cyc;
    int          stall_bad;

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    // Present an AR request and hold it until accepted (bounded).
    task automatic issue_ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        arid    = id;
        araddr  = addr;
        arlen   = len;
        arsize  = size;
        arburst = burst;
        arvalid = 1'b1;
        hs_cyc  = -1;
        for (int k = 0; k < 20; k++) begin
            if (arready) begin
                hs_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (hs_cyc < 0) begin
            errors++;
            $display("FAIL ar_accept got=no_handshake exp=handshake_within_20");
        end
        @(negedge clk);
        arvalid = 1'b0;
    endtask

    // Drive rready from pat (advancing only while rvalid) and record beats.
    task automatic collect(input int nbeats, input logic [15:0] pat);
        int          pidx;
        logic        prev_stall;
        logic [39:0] snap;
        logic [39:0] cur;
        pidx       = 0;
        prev_stall = 1'b0;
        snap       = '0;
        nb         = 0;
        first_cyc  = -1;
        stall_bad  = 0;
        for (int t = 0; t < 100 && nb < nbeats; t++) begin
            rready = pat[pidx[3:0]];
            cur    = {rvalid, rid, rdata, rresp, rlast};
            if (rvalid && first_cyc < 0) first_cyc = cyc;
            if (prev_stall && cur !== snap) stall_bad++;
            if (rvalid && rready) begin
                got_data[nb] = rdata;
                got_id[nb]   = rid;
                got_resp[nb] = rresp;
                got_last[nb] = rlast;
                got_cyc[nb]  = cyc;
                nb++;
            end
            prev_stall = rvalid && !rready;
            snap       = cur;
            if (rvalid) pidx++;
            @(negedge clk);
        end
        rready = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({arready, rvalid, rlast, rresp, rid, rdata} !== 40'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0", {arready, rvalid, rlast, rresp, rid, rdata});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (arready !== 1'b1 || rvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got=arready%b_rvalid%b exp=arready1_rvalid0", arready, rvalid);
        end
    endtask

    task automatic test_basic;
        for (int i = 0; i < 4; i++) preload(12'h010 + 12'(i), 32'hA0 + 32'(i));
        issue_ar(4'd5, 32'h40, 4'd3, 3'b010, 2'b01);
        collect(4, 16'hFFFF);
        checks++;
        if (nb !== 4) begin errors++; $display("FAIL basic_count got=%0d exp=4", nb); end
        checks++;
        if (first_cyc !== hs_cyc + 3) begin
            errors++;
            $display("FAIL basic_latency got=%0d exp=%0d", first_cyc - hs_cyc, 3);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_data[i] !== 32'hA0 + 32'(i)) begin
                errors++;
                $display("FAIL basic_data%0d got=%h exp=%h", i, got_data[i], 32'hA0 + 32'(i));
            end
            checks++;
            if ({got_id[i], got_resp[i], got_last[i]} !== {4'd5, 2'b00, (i == 3)}) begin
                errors++;
                $display("FAIL basic_ctl%0d got=id%0d_resp%b_last%b exp=id5_resp00_last%0d",
                         i, got_id[i], got_resp[i], got_last[i], (i == 3));
            end
            checks++;
            if (got_cyc[i] !== first_cyc + i) begin
                errors++;
                $display("FAIL basic_gap%0d got=%0d exp=%0d", i, got_cyc[i], first_cyc + i);
            end
        end
        checks++;
        if (arready !== 1'b1 || rvalid !== 1'b0) begin
            errors++;
            $display("FAIL basic_done got=arready%b_rvalid%b exp=arready1_rvalid0", arready, rvalid);
        end
    endtask

    task automatic test_backpressure;
        issue_ar(4'd5, 32'h40, 4'd3, 3'b010, 2'b01);
        collect(4, 16'hFFE9);
        checks++;
        if (nb !== 4 || stall_bad !== 0) begin
            errors++;
            $display("FAIL bp_stall got=beats%0d_unstable%0d exp=beats4_unstable0", nb, stall_bad);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({got_data[i], got_last[i]} !== {32'hA0 + 32'(i), (i == 3)}) begin
                errors++;
                $display("FAIL bp_beat%0d got=%h_last%b exp=%h_last%0d",
                         i, got_data[i], got_last[i], 32'hA0 + 32'(i), (i == 3));
            end
        end
        checks++;
        if (got_cyc[3] - first_cyc !== 6) begin
            errors++;
            $display("FAIL bp_span got=%0d exp=6", got_cyc[3] - first_cyc);
        end
        checks++;
        if (rvalid !== 1'b0) begin errors++; $display("FAIL bp_extra_beat got=1 exp=0"); end
    endtask

    task automatic test_misaligned;
        issue_ar(4'd3, 32'h42, 4'd1, 3'b010, 2'b01);
        collect(2, 16'hFFFF);
        checks++;
        if (nb !== 2) begin errors++; $display("FAIL mis_count got=%0d exp=2", nb); end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({got_data[i], got_resp[i], got_last[i], got_id[i]} !== {32'd0, 2'b10, (i == 1), 4'd3}) begin
                errors++;
                $display("FAIL mis_beat%0d got=%h_resp%b_last%b_id%0d exp=0_resp10_last%0d_id3",
                         i, got_data[i], got_resp[i], got_last[i], got_id[i], (i == 1));
            end
        end
    endtask

    task automatic test_bad_size;
        issue_ar(4'd4, 32'h44, 4'd0, 3'b001, 2'b01);
        collect(1, 16'hFFFF);
        checks++;
        if (nb !== 1 || {got_data[0], got_resp[0], got_last[0]} !== {32'd0, 2'b10, 1'b1}) begin
            errors++;
            $display("FAIL size_beat got=n%0d_%h_resp%b_last%b exp=n1_0_resp10_last1",
                     nb, got_data[0], got_resp[0], got_last[0]);
        end
        checks++;
        if (rvalid !== 1'b0) begin errors++; $display("FAIL size_single got=rvalid1 exp=rvalid0"); end
    endtask

    task automatic test_range;
        logic [31:0] exp_d [4];
        logic [1:0]  exp_r [4];
        exp_d = '{32'h1111_2222, 32'h3333_4444, 32'd0, 32'd0};
        exp_r = '{2'b00, 2'b00, 2'b10, 2'b10};
        preload(12'hFFE, 32'h1111_2222);
        preload(12'hFFF, 32'h3333_4444);
        issue_ar(4'd6, 32'h3FF8, 4'd3, 3'b010, 2'b01);
        collect(4, 16'hFFFF);
        checks++;
        if (nb !== 4) begin errors++; $display("FAIL range_count got=%0d exp=4", nb); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({got_data[i], got_resp[i], got_last[i]} !== {exp_d[i], exp_r[i], (i == 3)}) begin
                errors++;
                $display("FAIL range_beat%0d got=%h_resp%b_last%b exp=%h_resp%b_last%0d",
                         i, got_data[i], got_resp[i], got_last[i], exp_d[i], exp_r[i], (i == 3));
            end
        end
    endtask

    task automatic test_back_to_back;
        int hs1;
        int hs2;
        arid    = 4'd1;
        araddr  = 32'h40;
        arlen   = 4'd1;
        arsize  = 3'b010;
        arburst = 2'b01;
        arvalid = 1'b1;
        rready  = 1'b1;
        hs1     = -1;
        hs2     = -1;
        for (int k = 0; k < 20; k++) begin
            if (arready) begin
                hs1 = cyc;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        arid   = 4'd2;
        araddr = 32'h44;
        arlen  = 4'd0;
        nb     = 0;
        for (int t = 0; t < 40 && nb < 3; t++) begin
            if (arvalid && arready && hs2 < 0) hs2 = cyc;
            if (rvalid) begin
                got_data[nb] = rdata;
                got_id[nb]   = rid;
                got_last[nb] = rlast;
                got_cyc[nb]  = cyc;
                nb++;
            end
            @(negedge clk);
            if (hs2 >= 0) arvalid = 1'b0;
        end
        arvalid = 1'b0;
        checks++;
        if (hs1 < 0 || nb !== 3) begin
            errors++;
            $display("FAIL b2b_count got=hs1_%0d_beats%0d exp=accepted_beats3", hs1, nb);
        end
        checks++;
        if (got_cyc[0] !== hs1 + 3) begin
            errors++;
            $display("FAIL b2b_latency1 got=%0d exp=%0d", got_cyc[0], hs1 + 3);
        end
        checks++;
        if (hs2 !== got_cyc[1] + 1) begin
            errors++;
            $display("FAIL b2b_second_accept got=%0d exp=%0d", hs2, got_cyc[1] + 1);
        end
        checks++;
        if ({got_id[0], got_id[1], got_id[2], got_last[0], got_last[1], got_last[2]} !==
            {4'd1, 4'd1, 4'd2, 1'b0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL b2b_ids got=%0d%0d%0d_last%b%b%b exp=112_last011",
                     got_id[0], got_id[1], got_id[2], got_last[0], got_last[1], got_last[2]);
        end
        checks++;
        if (got_data[2] !== 32'hA1 || got_cyc[2] !== hs2 + 3) begin
            errors++;
            $display("FAIL b2b_second_beat got=%h_at%0d exp=a1_at%0d", got_data[2], got_cyc[2], hs2 + 3);
        end
    endtask

    task automatic test_reset_mid;
        int seen;
        logic hit;
        seen = 0;
        hit  = 1'b0;
        issue_ar(4'd7, 32'h40, 4'd7, 3'b010, 2'b01);
        rready = 1'b1;
        for (int t = 0; t < 40; t++) begin
            if (rvalid) begin
                if (seen == 1) begin
                    hit = 1'b1;
                    break;
                end
                seen++;
            end
            @(negedge clk);
        end
        checks++;
        if (!hit || rdata !== 32'hA1) begin
            errors++;
            $display("FAIL rstmid_beat2 got=hit%b_%h exp=hit1_a1", hit, rdata);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({arready, rvalid, rlast, rresp, rid, rdata} !== 40'd0) begin
            errors++;
            $display("FAIL rstmid_async got=%h exp=0", {arready, rvalid, rlast, rresp, rid, rdata});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (arready !== 1'b1 || rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_release got=arready%b_rvalid%b exp=arready1_rvalid0", arready, rvalid);
        end
        issue_ar(4'd9, 32'h44, 4'd1, 3'b010, 2'b01);
        collect(2, 16'hFFFF);
        checks++;
        if (nb !== 2 || {got_data[0], got_data[1], got_id[0], got_id[1], got_last[0], got_last[1],
                         got_resp[0], got_resp[1]} !== {32'hA1, 32'hA2, 4'd9, 4'd9, 1'b0, 1'b1, 2'b00, 2'b00}) begin
            errors++;
            $display("FAIL rstmid_fresh got=n%0d_%h_%h_id%0d_last%b%b exp=n2_a1_a2_id9_last01",
                     nb, got_data[0], got_data[1], got_id[1], got_last[0], got_last[1]);
        end
    endtask

    initial begin
        rst     = 1'b1;
        arid    = '0;
        araddr  = '0;
        arlen   = '0;
        arsize  = 3'b010;
        arburst = 2'b01;
        arvalid = 1'b0;
        rready  = 1'b1;
        ld_en   = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        test_reset;
        test_basic;
        test_backpressure;
        test_misaligned;
        test_bad_size;
        test_range;
        test_back_to_back;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
